timer_irq_controller: RTL and testbench
=======================================

Name: timer_irq_controller

Overview:
- Interrupt arbiter and sequencer between up to eight peripheral flag sources (counter_timer top/match0/match1 flags, etc.) and the CPU's single interrupt line.
- Selects one pending, enabled flag by fixed or round-robin priority, presents its index as a vector, and waits for the CPU acknowledge.
- After the acknowledge, pulses that source's flag-clear input.
- Sits on the I/O bus with the same register/handshake style as the other peripherals.

Parameters:
- IRQ_CTRL_ADDRESS, 8'h00, bus base address; registers at base+0..base+3.
- NUM_SOURCES, 8, number of flag sources (1..8); unused register bits read 0.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- din  input  8  bus write data
- address  input  8  bus address
- w_en  input  1  bus write strobe
- r_en  input  1  bus read strobe
- dout  output  8  bus read data, registered
- src_flag  input  NUM_SOURCES  level flags from sources (bit i = source i)
- src_flag_clr  output  NUM_SOURCES  one-cycle clear pulse per source
- irq  output  1  interrupt request to CPU
- irq_vector  output  3  index of source being requested
- irq_ack  input  1  CPU acknowledge, single-cycle pulse

Behaviour:
- Registers:
  - base+0 MASK: R/W, bit i enables source i.
  - base+1 CTRL: R/W; bit0 global enable, bit1 round-robin (0 = fixed, lowest index wins).
  - base+2 PENDING: RO, src_flag & MASK.
  - base+3 VECTOR: RO, {5'b0, last acknowledged index}.
- Bus rules:
  - Read latency 1 cycle; dout holds its value when r_en is low or the address is unmapped.
  - Writes to RO or unmapped addresses are ignored.
- Reset values: irq=0, irq_vector=0, src_flag_clr=0, dout=0, MASK=0, CTRL=0, rr_ptr=0, last vector=0, state IDLE.
- candidate = src_flag & MASK, gated by CTRL[0].
- FSM states: IDLE, ASSERT, CLEAR, SETTLE.
  - IDLE: if candidate is non-zero, latch the winner index into irq_vector and go to ASSERT. irq rises the cycle after the flag is seen (1-cycle latency).
  - ASSERT: irq=1; irq_vector is stable.
    - irq_ack=1: go to CLEAR and store the index as the last vector. If CTRL[1]=1, set rr_ptr to (index+1) mod NUM_SOURCES.
    - irq_ack=0 and candidate[index]=0 (flag cleared by software, masked, or globally disabled): withdraw. irq drops and the FSM returns to IDLE; the last vector is unchanged.
    - irq_ack and withdrawal in the same cycle: ack wins.
  - CLEAR: irq=0; src_flag_clr[index]=1 for exactly one cycle; next state SETTLE.
  - SETTLE: one guard cycle so a registered source's flag has dropped; then IDLE.
- Priority:
  - Fixed mode: lowest set index wins.
  - Round-robin mode: search starts at rr_ptr and wraps from NUM_SOURCES-1 to 0. rr_ptr advances only on ack, never on withdraw.
  - Changing CTRL[1] takes effect at the next IDLE arbitration.
- irq_ack in IDLE, CLEAR or SETTLE is ignored.
- At most one src_flag_clr bit is high in any cycle.
- A flag re-asserted by its source while its clear pulse is high is lost; clear has priority at the source.
- A flag still high at the end of SETTLE is re-arbitrated normally.
- rst in any state returns all state to reset values in the next cycle, including mid-ASSERT and mid-CLEAR; no clear pulse is emitted.

Decomposition:
- Shared package irq_ctrl_pkg:
  - state enum (IDLE/ASSERT/CLEAR/SETTLE);
  - register offset constants MASK_OFS=0, CTRL_OFS=1, PENDING_OFS=2, VECTOR_OFS=3;
  - CTRL bit positions CTRL_EN=0, CTRL_RR=1.
- One combinational sub-module, irq_priority_picker: inputs req[NUM_SOURCES], start pointer, mode; outputs valid and 3-bit index.

Test Plan:
- Fixed priority: MASK=8'hFF, CTRL=8'h01; src_flag=8'b0010_0100. Required: irq=1 one cycle later with irq_vector=2. Pulse irq_ack; then src_flag_clr=8'h04 for one cycle. Model drops bit 2; next, irq_vector=5.
- Round-robin: CTRL=8'h03; src_flag held at 8'h03, with the model ignoring clears. Successive acks must yield vectors 0,1,0,1; VECTOR register reads the last acked index.
- Masking and withdrawal: MASK=8'h01, src_flag=8'h02 gives no irq; PENDING reads 0. Then set src_flag=8'h01, wait for irq, write MASK=0 before any ack. Required: irq drops within 1 cycle, no src_flag_clr pulse, FSM back in IDLE.
- Ack/withdraw collision: during ASSERT on vector 3, drop src_flag[3] in the same cycle irq_ack=1. Required: src_flag_clr=8'h08 pulsed; VECTOR reads 3.
- Stray ack and reset: irq_ack in IDLE produces no clr pulse. Then assert rst during CLEAR. Required: src_flag_clr=0, irq=0, MASK/CTRL read 0, dout=0 the cycle after rst.
- Bus: write 8'hA5 to base+0, then read it with 1-cycle latency. A write to base+2 is ignored. A read of base+7 leaves dout unchanged.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irq_ctrl_pkg: shared state codes, register offsets and CTRL bits    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package irq_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ASSERT = 2'd1;
  localparam state_t ST_CLEAR  = 2'd2;
  localparam state_t ST_SETTLE = 2'd3;

  localparam logic [1:0] MASK_OFS    = 2'd0;
  localparam logic [1:0] CTRL_OFS    = 2'd1;
  localparam logic [1:0] PENDING_OFS = 2'd2;
  localparam logic [1:0] VECTOR_OFS  = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_RR = 1;

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/irq_priority_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irq_priority_picker: fixed / round-robin selection of one request  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module irq_priority_picker #(
  parameter int NUM_SOURCES = 8
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [2:0]             start_ptr,
  input  logic                   rr_mode,
  output logic                   valid,
  output logic [2:0]             index
);

  logic [2:0] w_start;

  // Fixed priority is round-robin anchored at source 0.
  assign w_start = rr_mode ? start_ptr : 3'd0;
  assign valid   = |req;

  // Descending scan so the candidate closest to the start pointer is written last.
  always_comb begin
    index = 3'd0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (w_start == 3'(s)) begin
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
          if (req[(s + k) % NUM_SOURCES]) begin
            index = 3'((s + k) % NUM_SOURCES);
          end
        end
      end
    end
  end

endmodule : irq_priority_picker
`default_nettype wire

// File: rtl/timer_irq_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_irq_controller: arbitrates peripheral flags onto one CPU irq |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module timer_irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter logic [7:0] IRQ_CTRL_ADDRESS = 8'h00,
  parameter int         NUM_SOURCES      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             din,
  input  logic [7:0]             address,
  input  logic                   w_en,
  input  logic                   r_en,
  output logic [7:0]             dout,
  input  logic [NUM_SOURCES-1:0] src_flag,
  output logic [NUM_SOURCES-1:0] src_flag_clr,
  output logic                   irq,
  output logic [2:0]             irq_vector,
  input  logic                   irq_ack
);

  function automatic logic [NUM_SOURCES-1:0] f_onehot(input logic [2:0] idx);
    logic [NUM_SOURCES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      v[i] = (idx == 3'(i));
    end
    return v;
  endfunction

  logic [NUM_SOURCES-1:0] r_mask;
  logic [1:0]             r_ctrl;
  logic [2:0]             r_rr_ptr;
  logic [2:0]             r_last_vec;
  state_t                 r_state;
  logic                   r_irq;
  logic [2:0]             r_vec;
  logic [NUM_SOURCES-1:0] r_clr;
  logic [7:0]             r_dout;

  logic [7:0]             w_ofs;
  logic                   w_mapped;
  logic [NUM_SOURCES-1:0] w_candidate;
  logic                   w_cand_hit;
  logic                   w_pick_valid;
  logic [2:0]             w_pick_idx;
  logic [2:0]             w_rr_next;

  assign w_ofs    = address - IRQ_CTRL_ADDRESS;
  assign w_mapped = (w_ofs[7:2] == 6'd0);

  assign w_candidate = src_flag & r_mask & {NUM_SOURCES{r_ctrl[CTRL_EN]}};
  assign w_cand_hit  = |(w_candidate & f_onehot(r_vec));
  assign w_rr_next   = (r_vec == 3'(NUM_SOURCES - 1)) ? 3'd0 : r_vec + 3'd1;

  irq_priority_picker #(
    .NUM_SOURCES (NUM_SOURCES)
  ) u_picker (
    .req       (w_candidate),
    .start_ptr (r_rr_ptr),
    .rr_mode   (r_ctrl[CTRL_RR]),
    .valid     (w_pick_valid),
    .index     (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
      r_ctrl <= 2'b00;
      r_dout <= 8'h00;
    end else begin
      if (w_en && w_mapped) begin
        case (w_ofs[1:0])
          MASK_OFS: r_mask <= din[NUM_SOURCES-1:0];
          CTRL_OFS: r_ctrl <= din[1:0];
          default:  ;
        endcase
      end
      if (r_en && w_mapped) begin
        case (w_ofs[1:0])
          MASK_OFS:    r_dout <= 8'(r_mask);
          CTRL_OFS:    r_dout <= {6'b0, r_ctrl};
          PENDING_OFS: r_dout <= 8'(src_flag & r_mask);
          default:     r_dout <= {5'b0, r_last_vec};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_irq      <= 1'b0;
      r_vec      <= 3'd0;
      r_clr      <= '0;
      r_rr_ptr   <= 3'd0;
      r_last_vec <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_vec   <= w_pick_idx;
            r_irq   <= 1'b1;
            r_state <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          // An acknowledge beats a flag that vanishes in the same cycle.
          if (irq_ack) begin
            r_irq      <= 1'b0;
            r_clr      <= f_onehot(r_vec);
            r_last_vec <= r_vec;
            if (r_ctrl[CTRL_RR]) begin
              r_rr_ptr <= w_rr_next;
            end
            r_state <= ST_CLEAR;
          end else if (!w_cand_hit) begin
            r_irq   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          r_clr   <= '0;
          r_state <= ST_SETTLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign irq          = r_irq;
  assign irq_vector   = r_vec;
  assign src_flag_clr = r_clr;

endmodule : timer_irq_controller
`default_nettype wire

// File: tb/tb_timer_irq_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_timer_irq_controller: scoreboard bench for the irq controller   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_timer_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [7:0] src_flag;
  logic [7:0] src_flag_clr;
  logic       irq;
  logic [2:0] irq_vector;
  logic       irq_ack;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_vec[$];
  logic [7:0] q_clr[$];
  logic [7:0] q_rd[$];

  logic prev_irq = 1'b0;
  logic rd_pend  = 1'b0;

  always #5 clk = ~clk;

  timer_irq_controller #(
    .IRQ_CTRL_ADDRESS (8'h00),
    .NUM_SOURCES      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .address      (address),
    .w_en         (w_en),
    .r_en         (r_en),
    .dout         (dout),
    .src_flag     (src_flag),
    .src_flag_clr (src_flag_clr),
    .irq          (irq),
    .irq_vector   (irq_vector),
    .irq_ack      (irq_ack)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [7:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h, none expected", nm, act);
  endtask

  // Monitor: every irq rise, clear pulse and completed read is matched against the queues.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (q_rd.size() == 0) unexpected("read_dout", dout);
      else check("read_dout", dout, q_rd.pop_front());
    end
    rd_pend = r_en && !rst;
    if (irq && !prev_irq) begin
      if (q_vec.size() == 0) unexpected("irq_vector", {5'b0, irq_vector});
      else check("irq_vector", {5'b0, irq_vector}, q_vec.pop_front());
    end
    prev_irq = irq;
    if (src_flag_clr != 8'h00) begin
      if (q_clr.size() == 0) unexpected("src_flag_clr", src_flag_clr);
      else check("src_flag_clr", src_flag_clr, q_clr.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    address = a;
    din     = d;
    w_en    = 1'b1;
    tick();
    w_en    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp);
    address = a;
    r_en    = 1'b1;
    q_rd.push_back(exp);
    tick();
    r_en    = 1'b0;
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!irq && n < 20) begin
      tick();
      n++;
    end
    check("irq_wait", {7'b0, irq}, 8'h01);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
    src_flag = 8'h00; irq_ack = 1'b0;
    ticks(3);
    check("reset_irq", {7'b0, irq}, 8'h00);
    check("reset_vector", {5'b0, irq_vector}, 8'h00);
    check("reset_clr", src_flag_clr, 8'h00);
    check("reset_dout", dout, 8'h00);
    rst = 1'b0;
    tick();

    // Fixed priority: lowest index first, then the remaining one.
    bus_write(8'h00, 8'hFF);
    bus_write(8'h01, 8'h01);
    q_vec.push_back(8'd2);
    src_flag = 8'b0010_0100;
    wait_irq();
    q_clr.push_back(8'h04);
    ack();
    q_vec.push_back(8'd5);
    src_flag[2] = 1'b0;
    wait_irq();
    q_clr.push_back(8'h20);
    ack();
    src_flag = 8'h00;
    ticks(3);
    bus_read(8'h03, 8'd5);

    // Round-robin with both flags held: 0,1,0,1.
    bus_write(8'h01, 8'h03);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      v = (i % 2 == 0) ? 8'd0 : 8'd1;
      q_vec.push_back(v);
      src_flag = 8'h03;
      wait_irq();
      q_clr.push_back(8'h01 << v);
      ack();
      bus_read(8'h03, v);
    end
    src_flag = 8'h00;
    ticks(3);

    // Masking and withdrawal.
    bus_write(8'h01, 8'h01);
    bus_write(8'h00, 8'h01);
    src_flag = 8'h02;
    ticks(3);
    check("masked_irq", {7'b0, irq}, 8'h00);
    bus_read(8'h02, 8'h00);
    q_vec.push_back(8'd0);
    src_flag = 8'h01;
    wait_irq();
    bus_write(8'h00, 8'h00);
    tick();
    check("withdraw_irq", {7'b0, irq}, 8'h00);
    ticks(3);
    bus_read(8'h03, 8'd1);
    q_vec.push_back(8'd0);
    bus_write(8'h00, 8'h01);
    wait_irq();
    q_clr.push_back(8'h01);
    ack();
    src_flag = 8'h00;
    ticks(3);

    // Ack and withdrawal in the same cycle.
    bus_write(8'h00, 8'hFF);
    q_vec.push_back(8'd3);
    src_flag = 8'h08;
    wait_irq();
    bus_read(8'h02, 8'h08);
    irq_ack  = 1'b1;
    src_flag = 8'h00;
    q_clr.push_back(8'h08);
    tick();
    irq_ack = 1'b0;
    tick();
    bus_read(8'h03, 8'd3);
    ticks(2);

    // Stray ack in IDLE, then reset during CLEAR.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    ticks(3);
    check("stray_ack_irq", {7'b0, irq}, 8'h00);
    bus_read(8'h00, 8'hFF);
    q_vec.push_back(8'd4);
    src_flag = 8'h10;
    wait_irq();
    q_clr.push_back(8'h10);
    ack();
    rst      = 1'b1;
    src_flag = 8'h00;
    tick();
    check("rst_clr", src_flag_clr, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_vector", {5'b0, irq_vector}, 8'h00);
    rst = 1'b0;
    bus_read(8'h00, 8'h00);
    bus_read(8'h01, 8'h00);
    bus_read(8'h03, 8'h00);

    // Bus behaviour.
    bus_write(8'h00, 8'hA5);
    bus_read(8'h00, 8'hA5);
    bus_write(8'h02, 8'hFF);
    bus_write(8'h04, 8'h3C);
    bus_read(8'h02, 8'h00);
    bus_read(8'h00, 8'hA5);
    bus_read(8'h07, 8'hA5);
    ticks(2);
    check("dout_hold", dout, 8'hA5);

    ticks(5);
    check("q_vec_drained", 8'(q_vec.size()), 8'h00);
    check("q_clr_drained", 8'(q_clr.size()), 8'h00);
    check("q_rd_drained", 8'(q_rd.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_timer_irq_controller
`default_nettype wire
